// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
// State encoding, default width and the divide-by-zero quotient.
package div_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [DEF_WIDTH-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/sub_stage.sv
// Combinational (W+1)-bit subtractor.
// borrow=1 means a < b, so the restoring step keeps the old remainder.
module sub_stage #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  always_comb begin
    {borrow, diff} = {1'b0, a} - {1'b0, b};
  end

endmodule

// File: rtl/seq_divider32.sv
// Iterative restoring divider for DIV/DIVU.
// One quotient bit per cycle on magnitudes, then a one-cycle sign fix.
module seq_divider32
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nx;

  logic [CW-1:0]  count;
  logic [WIDTH:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic sign_q;
  logic dvd_neg;
  logic dvs_neg;

  logic accept;
  logic dz;

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic borrow;

  logic [WIDTH-1:0] mag_dvd;
  logic [WIDTH-1:0] mag_dvs;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    dz       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            dz = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (count == LAST) state_nx = FIX;
      end
      FIX: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == FIX);

  always_comb begin
    mag_dvd = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_dvs = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // Shift {R,Q} left by one before the trial subtract.
  assign rem_sh = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};

  sub_stage #(
    .W(WIDTH + 1)
  ) u_sub (
    .a      (rem_sh),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_comb begin
    q_fix = (sign_q && (dvd_neg ^ dvs_neg)) ? -quo_q : quo_q;
    r_fix = (sign_q && dvd_neg) ? -rem_q[WIDTH-1:0]
                                : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sign_q      <= 1'b0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        count   <= '0;
        rem_q   <= '0;
        quo_q   <= mag_dvd;
        dvs_q   <= mag_dvs;
        sign_q  <= sign;
        dvd_neg <= sign && dividend[WIDTH-1];
        dvs_neg <= sign && divisor[WIDTH-1];
      end
      if (dz) begin
        done        <= 1'b1;
        div_by_zero <= 1'b1;
        quotient    <= WIDTH'(DIV_ZERO_Q);
        remainder   <= dividend;
      end
      if (state == RUN) begin
        rem_q <= borrow ? rem_sh : diff;
        quo_q <= {quo_q[WIDTH-2:0], ~borrow};
        count <= count + 1'b1;
      end
      if (state == FIX) begin
        quotient    <= q_fix;
        remainder   <= r_fix;
        div_by_zero <= 1'b0;
        done        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider32.sv
// Directed + scoreboard bench for seq_divider32.
// Expected results are queued at launch and popped on done.
module tb_seq_divider32;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_divider32 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sign        (sign),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Independent reference: 64-bit arithmetic cannot overflow.
  function automatic exp_t model(input logic s, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    longint sa;
    longint sd;
    if (s) begin
      sa = longint'($signed(a));
      sd = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sd = longint'({32'd0, b});
    end
    e.q = 32'(sa / sd);
    e.r = 32'(sa % sd);
    e.dbz = 1'b0;
    return e;
  endfunction

  task automatic launch(input logic s, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
    sign = s;
    dividend = a;
    divisor = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int c0,
                             input int lat, input int nbusy);
    int c;
    int nb;
    int chg;
    logic [31:0] q0;
    logic [31:0] r0;
    exp_t e;
    c = c0;
    nb = 0;
    chg = 0;
    q0 = quotient;
    r0 = remainder;
    while (c < 120) begin
      if (done) break;
      if (busy) nb++;
      if (quotient !== q0 || remainder !== r0) chg++;
      @(posedge clk);
      #1;
      c++;
    end
    check({tag, "_lat"}, c, lat);
    check({tag, "_busy"}, nb, nbusy);
    check({tag, "_hold"}, chg, 0);
    check({tag, "_sbq"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_q"}, quotient, e.q);
      check({tag, "_r"}, remainder, e.r);
      check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
    end
  endtask

  exp_t ex;
  int dcnt;
  logic [31:0] ra;
  logic [31:0] rb;
  logic rs;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sign = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", {31'd0, div_by_zero}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    ex = '{q: 32'd14, r: 32'd2, dbz: 1'b0};
    launch(1'b0, 32'd100, 32'd7, ex);
    wait_result("divu100_7", 1, 34, 33);
    @(posedge clk);
    #1;
    check("done_pulse", {31'd0, done}, 0);

    ex = '{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dbz: 1'b0};
    launch(1'b1, 32'hFFFF_FFF9, 32'd2, ex);
    wait_result("div_m7_2", 1, 34, 33);

    ex = '{q: 32'hFFFF_FFFD, r: 32'd1, dbz: 1'b0};
    launch(1'b1, 32'd7, 32'hFFFF_FFFE, ex);
    wait_result("div_7_m2", 1, 34, 33);

    ex = '{q: 32'h8000_0000, r: 32'd0, dbz: 1'b0};
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, ex);
    wait_result("div_ovf", 1, 34, 33);

    ex = '{q: 32'd0, r: 32'h8000_0000, dbz: 1'b0};
    launch(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, ex);
    wait_result("divu_big", 1, 34, 33);

    ex = '{q: 32'hFFFF_FFFF, r: 32'd5, dbz: 1'b1};
    launch(1'b0, 32'd5, 32'd0, ex);
    wait_result("dbz", 1, 1, 0);
    @(posedge clk);
    #1;
    check("dbz_pulse", {31'd0, done}, 0);
    check("dbz_busy", {31'd0, busy}, 0);

    // Second start mid-RUN must be dropped.
    ex = '{q: 32'd20, r: 32'd3, dbz: 1'b0};
    launch(1'b0, 32'd123, 32'd6, ex);
    repeat (5) @(posedge clk);
    #1;
    dividend = 32'd999;
    divisor = 32'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_result("ignore", 7, 34, 27);

    // Launch on the done cycle itself.
    launch(1'b1, 32'hFFFF_FF9C, 32'd7, model(1'b1, 32'hFFFF_FF9C, 32'd7));
    wait_result("b2b_a", 1, 34, 33);
    launch(1'b0, 32'd1000, 32'd33, model(1'b0, 32'd1000, 32'd33));
    wait_result("b2b_b", 1, 34, 33);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (rb == 0) rb = 32'd3;
      if (i == 1) rb = rb >> 20;
      rs = 1'(i & 1);
      launch(rs, ra, rb, model(rs, ra, rb));
      wait_result("rand", 1, 34, 33);
    end

    // Reset at count=10 aborts the operation.
    ex = '{q: 32'd14, r: 32'd2, dbz: 1'b0};
    launch(1'b0, 32'd100, 32'd7, ex);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dbz", {31'd0, div_by_zero}, 0);
    rst = 1'b0;
    void'(sb.pop_front());
    dcnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) dcnt++;
    end
    check("abort_nodone", dcnt, 0);

    ex = '{q: 32'd14, r: 32'd2, dbz: 1'b0};
    launch(1'b0, 32'd100, 32'd7, ex);
    wait_result("after_rst", 1, 34, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
